// File: rtl/fp32_pkg.sv
// Shared FP32 field constants, sequencer state encoding and a special-value helper.
package fp32_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_W    = 23;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Inf or NaN: exponent field all ones
  function automatic logic is_special(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB] == EXP_ALL1;
  endfunction

endpackage

// File: rtl/fp_accum_seq.sv
// Packet accumulator sequencer around an external combinational FP32 adder.
// Optional FP_ACCUM_SPECIAL_EN adds a sticky Inf/NaN flag on out_special.
module fp_accum_seq
  import fp32_pkg::*;
#(
  parameter int unsigned ADD_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
`ifdef FP_ACCUM_SPECIAL_EN
  ,
  output logic             out_special
`endif
);

  localparam int unsigned     LAT_W   = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(ADD_LAT);

  state_t           state, state_nxt;
  logic [31:0]      acc, opnd;
  logic [CNT_W-1:0] count;
  logic [LAT_W-1:0] lat_cnt;
  logic             last_r;
  logic             in_xfer, out_xfer, add_done;

  // State is already IDLE during reset, so readiness is masked explicitly
  assign in_ready  = !reset && ((state == IDLE) || (state == ACC));
  assign out_valid = (state == OUT);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign add_done  = (state == ADD) && (lat_cnt == LAT_END);

  assign add_a     = acc;
  assign add_b     = opnd;
  assign out_data  = out_valid ? acc : '0;
  assign out_count = out_valid ? count : '0;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_xfer)   state_nxt = in_last ? OUT : ACC;
      ACC:  if (in_xfer)   state_nxt = ADD;
      ADD:  if (add_done)  state_nxt = last_r ? OUT : ACC;
      OUT:  if (out_xfer)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      lat_cnt <= '0;
      last_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_xfer) begin
          acc   <= in_data;
          count <= CNT_W'(1);
        end
        ACC: if (in_xfer) begin
          opnd    <= in_data;
          last_r  <= in_last;
          count   <= (&count) ? count : count + 1'b1;
          lat_cnt <= '0;
        end
        ADD: begin
          if (add_done) acc     <= add_c;
          else          lat_cnt <= lat_cnt + 1'b1;
        end
        OUT: if (out_xfer) count <= '0;
        default: ;
      endcase
    end
  end

`ifdef FP_ACCUM_SPECIAL_EN
  logic special_r;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      special_r <= 1'b0;
    else if (out_xfer)
      special_r <= 1'b0;
    else if ((in_xfer && is_special(in_data)) || (add_done && is_special(add_c)))
      special_r <= 1'b1;
  end

  assign out_special = special_r;
`endif

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench: two sequencer instances (ADD_LAT=0/CNT_W=16, ADD_LAT=2/CNT_W=2) each with a behavioural FP32 adder.
module tb_fp_accum_seq;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        in_last   [2];
  logic [31:0] add_a     [2];
  logic [31:0] add_b     [2];
  logic [31:0] add_c     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic [15:0] oc0;
  logic [1:0]  oc1;
`ifdef FP_ACCUM_SPECIAL_EN
  logic        sp [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] pkt [16];
  int          pkt_len;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Truncating adder for positive normals; Inf/NaN operands give +Inf
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    int ex, ey, d;
    logic [24:0] mx, my, s;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7F800000;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d  = ex - ey;
    if (d > 24) return x;
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]} >> d;
    s  = mx + my;
    if (s[24]) begin s = s >> 1; ex++; end
    if (ex >= 255) return 32'h7F800000;
    return {1'b0, 8'(ex), s[22:0]};
  endfunction

  assign add_c[0] = fp_add(add_a[0], add_b[0]);
  assign add_c[1] = fp_add(add_a[1], add_b[1]);

  fp_accum_seq #(.ADD_LAT(0), .CNT_W(16)) u0 (
    .sysclk(sysclk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .add_a(add_a[0]), .add_b(add_b[0]), .add_c(add_c[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_count(oc0)
`ifdef FP_ACCUM_SPECIAL_EN
    , .out_special(sp[0])
`endif
  );

  fp_accum_seq #(.ADD_LAT(2), .CNT_W(2)) u1 (
    .sysclk(sysclk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .add_a(add_a[1]), .add_b(add_b[1]), .add_c(add_c[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_count(oc1)
`ifdef FP_ACCUM_SPECIAL_EN
    , .out_special(sp[1])
`endif
  );

  function automatic logic [31:0] ocnt(input int d);
    return (d == 0) ? {16'd0, oc0} : {30'd0, oc1};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int sat_of(input int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_pkt(input int d, input bit toggle,
                          output int first_c, output int last_c, output int nrz);
    bit ph, done;
    int w;
    ph = 1'b0; nrz = 0; first_c = 0; last_c = 0;
    for (int i = 0; i < pkt_len; i++) begin
      in_data[d] = pkt[i];
      in_last[d] = (i == pkt_len - 1);
      done = 1'b0;
      w = 0;
      while (!done && w < 200) begin
        in_valid[d] = toggle ? ph : 1'b1;
        ph = !ph;
        if (i > 0 && !in_ready[d]) nrz++;
        done = in_valid[d] && in_ready[d];
        tick();
        w++;
      end
      if (!done) check("in_timeout", 32'd0, 32'd1);
      if (i == 0) first_c = cyc;
      last_c = cyc;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic collect(input int d, input logic [31:0] exp_d, input logic [31:0] exp_c,
                         input logic exp_sp, input int hold, output int out_c);
    int w;
    w = 0;
    while (!out_valid[d] && w < 100) begin tick(); w++; end
    check("out_valid", 32'(out_valid[d]), 32'd1);
    out_c = cyc;
    check("out_data", out_data[d], exp_d);
    check("out_count", ocnt(d), exp_c);
`ifdef FP_ACCUM_SPECIAL_EN
    check("out_special", 32'(sp[d]), 32'(exp_sp));
`else
    if (exp_sp) w = 0;
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(out_valid[d]), 32'd1);
      check("hold_data", out_data[d], exp_d);
      check("hold_count", ocnt(d), exp_c);
      check("hold_in_ready", 32'(in_ready[d]), 32'd0);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check("post_out_valid", 32'(out_valid[d]), 32'd0);
    check("post_in_ready", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic run_pkt(input int d, input bit toggle, input int hold);
    logic [31:0] sum, cnt;
    logic        spc;
    int f, l, nz, o, lat;
    sum = pkt[0];
    spc = (pkt[0][30:23] == 8'hFF);
    for (int i = 1; i < pkt_len; i++) begin
      sum = fp_add(sum, pkt[i]);
      spc = spc || (pkt[i][30:23] == 8'hFF) || (sum[30:23] == 8'hFF);
    end
    cnt = 32'((pkt_len > sat_of(d)) ? sat_of(d) : pkt_len);
    lat = lat_of(d);
    send_pkt(d, toggle, f, l, nz);
    collect(d, sum, cnt, spc, hold, o);
    if (!toggle) check("lat_first", 32'(o - f + 1), 32'(1 + (pkt_len - 1) * (lat + 2)));
    check("lat_last", 32'(o - l), 32'((pkt_len > 1) ? lat + 1 : 0));
    check("busy_cycles", 32'(nz), 32'((pkt_len > 1) ? (pkt_len - 2) * (lat + 1) : 0));
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b0;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 32'd0);
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out_data", out_data[d], 32'd0);
      check("rst_out_count", ocnt(d), 32'd0);
      check("rst_add_a", add_a[d], 32'd0);
      check("rst_add_b", add_b[d], 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel_in_ready0", 32'(in_ready[0]), 32'd1);
    check("rel_in_ready1", 32'(in_ready[1]), 32'd1);

    // Reset asserted while u1 is mid-add
    in_data[1] = 32'h3F800000; in_last[1] = 1'b0; in_valid[1] = 1'b1;
    tick();
    in_data[1] = 32'h40000000;
    tick();
    in_valid[1] = 1'b0;
    check("midadd_busy", 32'(in_ready[1]), 32'd0);
    check("midadd_add_a", add_a[1], 32'h3F800000);
    check("midadd_add_b", add_b[1], 32'h40000000);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready[1]), 32'd0);
    check("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    check("midrst_add_a", add_a[1], 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_rel_ready", 32'(in_ready[1]), 32'd1);
    check("midrst_rel_valid", 32'(out_valid[1]), 32'd0);

    pkt_len = 1; pkt[0] = 32'h3F800000;
    run_pkt(0, 1'b0, 0);

    pkt_len = 3; pkt[0] = 32'h3F800000; pkt[1] = 32'h40000000; pkt[2] = 32'h3F000000;
    run_pkt(0, 1'b0, 0);
    check("dir_sum_const", fp_add(fp_add(pkt[0], pkt[1]), pkt[2]), 32'h40600000);
    run_pkt(1, 1'b1, 0);
    run_pkt(0, 1'b0, 10);
    run_pkt(0, 1'b0, 0);

    pkt_len = 5;
    for (int i = 0; i < 5; i++) pkt[i] = 32'h3F800000;
    run_pkt(1, 1'b0, 2);

`ifdef FP_ACCUM_SPECIAL_EN
    pkt_len = 2; pkt[0] = 32'h3F800000; pkt[1] = 32'h7F800000;
    run_pkt(0, 1'b0, 0);
    pkt_len = 1; pkt[0] = 32'h40000000;
    run_pkt(0, 1'b0, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      pkt_len = int'($urandom_range(1, 6));
      for (int i = 0; i < pkt_len; i++)
        pkt[i] = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
      run_pkt(n % 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequencing stage that wraps the combinational FP32 adder.
- Accepts a packet of IEEE-754 single-precision operands over a valid/ready stream.
- Drives the adder's a/b inputs from its accumulator and operand registers, and captures the adder's c output back into the accumulator.
- Emits the packet sum and element count over an output valid/ready stream.

Parameters:
- ADD_LAT, 0, extra cycles operands are held before capturing add_c (0 = combinational adder, capture at end of first ADD cycle).
- CNT_W, 16, width of element counter; also the width of out_count.

Ports:
- sysclk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept operand this cycle.
- in_data  input  32  FP32 operand.
- in_last  input  1  operand is final element of packet.
- add_a  output  32  to adder a: accumulator register.
- add_b  output  32  to adder b: operand register.
- add_c  input  32  from adder c: sum.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  FP32 packet sum.
- out_count  output  CNT_W  number of elements in packet.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, opnd=0, count=0, lat_cnt=0, last_r=0. Outputs in_ready=0, out_valid=0, out_data=0, out_count=0, add_a=0, add_b=0.
- Handshakes: an input transfer occurs on a sysclk edge with in_valid&in_ready; an output transfer occurs with out_valid&out_ready.
- in_ready=1 only in IDLE and ACC; combinational from state only, never from in_valid.
- States:
  - IDLE: in_ready=1. On transfer: acc<=in_data (first element loaded directly, no add), count<=1. If in_last, go to OUT; else go to ACC.
  - ACC: in_ready=1. On transfer: opnd<=in_data, last_r<=in_last, count<=count+1, lat_cnt<=0, go to ADD. No transfer: stay.
  - ADD: in_ready=0; add_a=acc and add_b=opnd held stable. If lat_cnt==ADD_LAT: acc<=add_c, then go to OUT if last_r, else ACC. Otherwise lat_cnt<=lat_cnt+1.
  - OUT: out_valid=1, out_data=acc, out_count=count. Both are stable while out_valid&!out_ready. On transfer: go to IDLE, count<=0.
- Latency:
  - Single-element packet: result valid 1 cycle after input transfer.
  - Each additional element costs 1 accept cycle + (ADD_LAT+1) ADD cycles.
- Counter saturates at all-ones; further elements are still summed.
- in_valid in ADD/OUT is ignored (back-pressure); upstream must hold data.
- The block does no arithmetic itself: rounding, denormals and specials are the adder's responsibility.
- Reset asserted mid-packet discards the partial sum and drops any pending out_valid the same cycle.

Optional Feature:
- Macro FP_ACCUM_SPECIAL_EN.
- Defined:
  - Adds output port out_special (1 bit), valid with out_valid.
  - out_special is a sticky flag set if any accepted in_data, or any captured add_c, has exponent 8'hFF (Inf/NaN).
  - Cleared on output transfer and on reset.
- Undefined: port absent, no detection logic.

Decomposition:
- Shared package fp32_pkg:
  - field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_ALL1=8'hFF.
  - state enum (IDLE, ACC, ADD, OUT).
  - constants FP_ONE=32'h3F800000, FP_ZERO=32'h0.
- No sub-module natural; the adder is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Reset mid-ADD (assert reset while state=ADD) -> immediately in_ready=0, out_valid=0, add_a=0; after release, IDLE with in_ready=1.
- Single element 32'h3F800000 with last=1 -> next cycle out_valid=1, out_data=32'h3F800000, out_count=1.
- Packet 1.0, 2.0, 0.5 (3F800000, 40000000, 3F000000 last), ADD_LAT=0 -> out_data=32'h40600000, out_count=3; result valid 5 cycles after first transfer with in_valid held high.
- Same packet, ADD_LAT=2, in_valid toggled every other cycle -> identical result; in_ready=0 for exactly 3 cycles per add.
- out_ready held 0 for 10 cycles after result -> out_valid, out_data and out_count stable; in_ready=0 throughout; next packet accepted the cycle after transfer.
- With FP_ACCUM_SPECIAL_EN: packet 3F800000, 7F800000 (last) -> out_special=1; following packet 40000000 -> out_special=0.
